// File: rtl/icetap_capture_ctrl.sv
// Capture sequencer for one icetap run: gates sample RAM writes from the store and trigger
// comparators, records where the trigger landed and counts the post-trigger samples.
module icetap_capture_ctrl #(
    parameter int ADDR_BITS = 8,
    parameter int CMD_BITS  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    input  logic [CMD_BITS-1:0]  cmd,
    input  logic                 store_in,
    input  logic                 trigger_in,
    input  logic [ADDR_BITS-1:0] post_trig_len,
    output logic                 ram_we,
    output logic [ADDR_BITS-1:0] ram_waddr,
    output logic [ADDR_BITS-1:0] trigger_addr,
    output logic                 wrapped,
    output logic                 triggered,
    output logic                 done,
    output logic [1:0]           state
);

    localparam logic [CMD_BITS-1:0] CMD_START = CMD_BITS'(1);
    localparam logic [CMD_BITS-1:0] CMD_ABORT = CMD_BITS'(2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    logic                 r_we;
    logic [ADDR_BITS-1:0] r_waddr;
    logic [ADDR_BITS-1:0] r_trig_addr;
    logic                 r_wrapped;
    logic                 r_triggered;
    logic                 r_done;
    logic [ADDR_BITS-1:0] r_post_cnt;

    state_t               w_state_next;
    logic                 w_we_next;
    logic [ADDR_BITS-1:0] w_waddr_next;
    logic [ADDR_BITS-1:0] w_trig_addr_next;
    logic                 w_wrapped_next;
    logic                 w_triggered_next;
    logic                 w_done_next;
    logic [ADDR_BITS-1:0] w_post_cnt_next;

    logic                 w_start;
    logic                 w_abort;
    logic [ADDR_BITS-1:0] w_cur_addr;

    assign w_start    = cmd_valid && (cmd == CMD_START);
    assign w_abort    = cmd_valid && (cmd == CMD_ABORT);
    // Address the write decided this edge will land on, accounting for the write still in flight.
    assign w_cur_addr = r_we ? (r_waddr + ADDR_BITS'(1)) : r_waddr;

    always_comb begin
        w_state_next     = r_state;
        w_we_next        = 1'b0;
        w_waddr_next     = w_cur_addr;
        w_trig_addr_next = r_trig_addr;
        w_wrapped_next   = r_wrapped || (r_we && (r_waddr == '1));
        w_triggered_next = r_triggered;
        w_done_next      = r_done;
        w_post_cnt_next  = r_post_cnt;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start) begin
                    w_state_next     = S_ARMED;
                    w_waddr_next     = '0;
                    w_trig_addr_next = '0;
                    w_wrapped_next   = 1'b0;
                    w_triggered_next = 1'b0;
                    w_done_next      = 1'b0;
                end else if (w_abort && (r_state == S_DONE)) begin
                    w_state_next = S_IDLE;
                end
            end
            S_ARMED: begin
                if (w_abort) begin
                    w_state_next = S_IDLE;
                end else if (trigger_in) begin
                    // The port width already bounds the post count to DEPTH-1, so the
                    // trigger sample can never be overwritten by its own post-trigger run.
                    w_we_next        = 1'b1;
                    w_trig_addr_next = w_cur_addr;
                    w_triggered_next = 1'b1;
                    w_post_cnt_next  = post_trig_len;
                    if (post_trig_len == '0) begin
                        w_state_next = S_DONE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_state_next = S_POST;
                    end
                end else if (store_in) begin
                    w_we_next = 1'b1;
                end
            end
            S_POST: begin
                if (w_abort) begin
                    w_state_next = S_IDLE;
                end else if (store_in) begin
                    w_we_next       = 1'b1;
                    w_post_cnt_next = r_post_cnt - ADDR_BITS'(1);
                    if (r_post_cnt == ADDR_BITS'(1)) begin
                        w_state_next = S_DONE;
                        w_done_next  = 1'b1;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_trig_addr <= '0;
            r_wrapped   <= 1'b0;
            r_triggered <= 1'b0;
            r_done      <= 1'b0;
            r_post_cnt  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_we        <= w_we_next;
            r_waddr     <= w_waddr_next;
            r_trig_addr <= w_trig_addr_next;
            r_wrapped   <= w_wrapped_next;
            r_triggered <= w_triggered_next;
            r_done      <= w_done_next;
            r_post_cnt  <= w_post_cnt_next;
        end
    end

    assign ram_we       = r_we;
    assign ram_waddr    = r_waddr;
    assign trigger_addr = r_trig_addr;
    assign wrapped      = r_wrapped;
    assign triggered    = r_triggered;
    assign done         = r_done;
    assign state        = r_state;

endmodule

// File: tb/tb_icetap_capture_ctrl.sv
// Bench for icetap_capture_ctrl: a run-level reference model queues expected RAM writes,
// an independent monitor checks every ram_we against that queue.
module tb_icetap_capture_ctrl;

    localparam int AB    = 4;
    localparam int CB    = 3;
    localparam int DEPTH = 1 << AB;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [CB-1:0] cmd = '0;
    logic          store_in = 1'b0;
    logic          trigger_in = 1'b0;
    logic [AB-1:0] post_trig_len = '0;
    logic          ram_we;
    logic [AB-1:0] ram_waddr;
    logic [AB-1:0] trigger_addr;
    logic          wrapped;
    logic          triggered;
    logic          done;
    logic [1:0]    state;

    icetap_capture_ctrl #(.ADDR_BITS(AB), .CMD_BITS(CB)) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd           (cmd),
        .store_in      (store_in),
        .trigger_in    (trigger_in),
        .post_trig_len (post_trig_len),
        .ram_we        (ram_we),
        .ram_waddr     (ram_waddr),
        .trigger_addr  (trigger_addr),
        .wrapped       (wrapped),
        .triggered     (triggered),
        .done          (done),
        .state         (state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int addr;
        int edge_no;
    } wr_t;
    wr_t exp_q[$];

    // Reference model: phase 0 idle, 1 armed, 2 post, 3 done; m_count = writes since START/reset.
    int m_phase = 0;
    int m_count = 0;
    int m_post = 0;
    int m_trig_addr = 0;
    int m_triggered = 0;
    int m_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, edge_cnt);
        end
    endtask

    initial begin : monitor
        wr_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].edge_no < edge_cnt) begin
                e = exp_q.pop_front();
                n_cmp++;
                n_err++;
                $display("FAIL missing_write: no ram_we for addr %0d, required in cycle %0d", e.addr, e.edge_no);
            end
            if (ram_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: got ram_we at addr %0d cycle %0d, required none", ram_waddr, edge_cnt);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", 32'(ram_waddr), e.addr);
                    check("write_cycle", edge_cnt, e.edge_no);
                end
            end
        end
    end

    task automatic push_write();
        exp_q.push_back('{addr: m_count % DEPTH, edge_no: edge_cnt + 1});
        m_count++;
    endtask

    task automatic model(input bit rst, input bit cv, input bit [2:0] c, input bit st, input bit tr, input bit [3:0] pl);
        bit start_c = cv && (c == 3'd1);
        bit abort_c = cv && (c == 3'd2);
        if (rst) begin
            m_phase = 0; m_count = 0; m_post = 0;
            m_trig_addr = 0; m_triggered = 0; m_done = 0;
        end else begin
            case (m_phase)
                0, 3: begin
                    if (start_c) begin
                        m_phase = 1; m_count = 0;
                        m_trig_addr = 0; m_triggered = 0; m_done = 0;
                    end else if (abort_c && m_phase == 3) begin
                        m_phase = 0;
                    end
                end
                1: begin
                    if (abort_c) begin
                        m_phase = 0;
                    end else if (tr) begin
                        m_trig_addr = m_count % DEPTH;
                        m_triggered = 1;
                        push_write();
                        if (pl == 0) begin
                            m_phase = 3; m_done = 1;
                        end else begin
                            m_post = int'(pl); m_phase = 2;
                        end
                    end else if (st) begin
                        push_write();
                    end
                end
                default: begin
                    if (abort_c) begin
                        m_phase = 0;
                    end else if (st) begin
                        push_write();
                        m_post--;
                        if (m_post == 0) begin
                            m_phase = 3; m_done = 1;
                        end
                    end
                end
            endcase
        end
    endtask

    // Inputs change just after the falling edge; per-cycle status is compared after the next rise.
    task automatic step(input bit rst, input bit cv, input bit [2:0] c, input bit st, input bit tr, input bit [3:0] pl);
        reset = rst; cmd_valid = cv; cmd = c; store_in = st; trigger_in = tr; post_trig_len = pl;
        model(rst, cv, c, st, tr, pl);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("state", 32'(state), m_phase);
        check("done", 32'(done), m_done);
        check("triggered", 32'(triggered), m_triggered);
        check("trigger_addr", 32'(trigger_addr), m_trig_addr);
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 3'd0, 0, 0, 4'd0);
        check("ram_waddr", 32'(ram_waddr), m_count % DEPTH);
        check("wrapped", 32'(wrapped), (m_count >= DEPTH) ? 1 : 0);
        check("queue_empty", exp_q.size(), 0);
    endtask

    initial begin : stim
        @(negedge clk);
        #1;
        step(1, 0, 3'd0, 0, 0, 4'd0);
        step(1, 0, 3'd0, 1, 1, 4'd0);
        check("rst_ram_we", 32'(ram_we), 0);
        check("rst_waddr", 32'(ram_waddr), 0);
        check("rst_wrapped", 32'(wrapped), 0);
        settle(1);

        // Trigger on the 5th stored sample with three post samples; DONE ignores store/trigger.
        step(0, 1, 3'd1, 0, 0, 4'd0);
        for (int i = 0; i < 5; i++) step(0, 0, 3'd0, 1, (i == 4), 4'd3);
        for (int i = 0; i < 3; i++) step(0, 0, 3'd0, 1, 0, 4'd9);
        for (int i = 0; i < 3; i++) step(0, 0, 3'd0, 1, 1, 4'd0);
        settle(2);
        check("t1_trigger_addr", 32'(trigger_addr), 4);
        check("t1_waddr", 32'(ram_waddr), 8);
        check("t1_state", 32'(state), 3);

        // Wrap: trigger after 20 samples, maximum post length, trigger sample survives.
        step(0, 1, 3'd1, 0, 0, 4'd0);
        for (int i = 0; i < 20; i++) step(0, 0, 3'd0, 1, 0, 4'd0);
        step(0, 0, 3'd0, 1, 1, 4'd15);
        for (int i = 0; i < 15; i++) step(0, 0, 3'd0, 1, 0, 4'd2);
        settle(2);
        check("t2_wrapped", 32'(wrapped), 1);
        check("t2_trigger_addr", 32'(trigger_addr), 4);
        check("t2_waddr", 32'(ram_waddr), 4);

        // Lone trigger with zero post length: single write at 0, DONE right after.
        step(0, 1, 3'd1, 0, 0, 4'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 3'd0, 0, 0, 4'd7);
        step(0, 0, 3'd0, 0, 1, 4'd0);
        check("t3_state", 32'(state), 3);
        settle(2);

        // ABORT beats a simultaneous trigger; a fresh START clears the address.
        step(0, 1, 3'd1, 0, 0, 4'd0);
        step(0, 0, 3'd0, 1, 0, 4'd0);
        step(0, 0, 3'd0, 1, 0, 4'd0);
        step(0, 1, 3'd2, 1, 1, 4'd5);
        check("t4_triggered", 32'(triggered), 0);
        check("t4_state", 32'(state), 0);
        settle(2);
        step(0, 1, 3'd1, 0, 0, 4'd0);
        check("t4_waddr_after_start", 32'(ram_waddr), 0);
        step(0, 1, 3'd2, 0, 0, 4'd0);
        settle(2);

        // START ignored in POST, then reset mid-POST clears everything.
        step(0, 1, 3'd1, 0, 0, 4'd0);
        step(0, 0, 3'd0, 1, 1, 4'd10);
        step(0, 0, 3'd0, 1, 0, 4'd0);
        step(0, 1, 3'd1, 1, 0, 4'd0);
        step(0, 0, 3'd0, 1, 0, 4'd0);
        step(1, 0, 3'd0, 1, 0, 4'd0);
        check("t5_ram_we", 32'(ram_we), 0);
        check("t5_waddr", 32'(ram_waddr), 0);
        check("t5_wrapped", 32'(wrapped), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 3'd0, 1, 1, 4'd3);
        settle(1);

        // Alternating store in POST: skipped cycles do not consume post count.
        step(0, 1, 3'd1, 0, 0, 4'd0);
        step(0, 0, 3'd0, 0, 1, 4'd4);
        for (int i = 0; i < 8; i++) step(0, 0, 3'd0, (i % 2 == 1), 0, 4'd1);
        settle(2);

        for (int run = 0; run < 40; run++) begin
            int len = $urandom_range(5, 60);
            int sp = $urandom_range(1, 3);
            step(0, 1, 3'd2, 0, 0, 4'd0);
            settle(2);
            step(0, 1, 3'd1, 0, 0, 4'd0);
            for (int i = 0; i < len; i++) begin
                int r = $urandom_range(0, 99);
                bit [2:0] c = (r < 3) ? 3'd1 : (r < 5) ? 3'd2 : 3'($urandom_range(0, 7));
                step((r == 99), (r < 7), c, ($urandom_range(0, 3) < sp),
                     ($urandom_range(0, 19) == 0), 4'($urandom_range(0, 15)));
            end
            settle(3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
